// File: rtl/surf_capture_pkg.sv
// -----------------------------------------------------------------------------
// surf_capture_pkg
// Shared helpers for the SURF multi-byte capture block:
//   - phase_w      : phase counter width for a given byte-period length
//   - *_legal      : legal-range checks for the period, enable delay and
//                    error counter width
//   - err_sat      : saturation value of an error counter of a given width
// No ports; imported by surf_multi_byte_capture and surf_byte_capture_chan.
// -----------------------------------------------------------------------------
package surf_capture_pkg;

    localparam int NPHASE_MIN = 2;
    localparam int NPHASE_MAX = 16;
    localparam int ENDLY_MIN  = 1;
    localparam int ENDLY_MAX  = 32;
    localparam int ERRW_MIN   = 1;
    localparam int ERRW_MAX   = 32;

    function automatic int phase_w(input int nphase);
        return (nphase > 1) ? $clog2(nphase) : 1;
    endfunction

    function automatic bit nphase_legal(input int nphase);
        return (nphase >= NPHASE_MIN) && (nphase <= NPHASE_MAX);
    endfunction

    function automatic bit endly_legal(input int endly);
        return (endly >= ENDLY_MIN) && (endly <= ENDLY_MAX);
    endfunction

    function automatic bit errw_legal(input int errw);
        return (errw >= ERRW_MIN) && (errw <= ERRW_MAX);
    endfunction

    function automatic logic [63:0] err_sat(input int errw);
        return (64'd1 << errw) - 64'd1;
    endfunction

endpackage

// File: rtl/surf_byte_capture_chan.sv
// -----------------------------------------------------------------------------
// surf_byte_capture_chan
// One capture channel: one-shot arm latch, word store with valid pulse,
// enable-fall delay line, repeat-pattern history, bit-error flag and
// saturating error counter.
// Ports:
//   clk, rst      : system clock, async active-high reset
//   boundary      : high on the last phase of the byte period (from parent)
//   capture       : single-cycle one-shot capture request
//   enable        : continuous streaming enable
//   errcnt_clr    : synchronous clear of the error counter
//   din           : deserialised word
//   dout, valid   : captured word and one-cycle update pulse
//   biterr        : registered repeat-pattern mismatch flag
//   errcnt        : saturating mismatch count
// -----------------------------------------------------------------------------
module surf_byte_capture_chan
    import surf_capture_pkg::*;
#(
    parameter int NBITS  = 8,
    parameter int NPHASE = 2,
    parameter int ENDLY  = 16,
    parameter int ERRW   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             boundary,
    input  logic             capture,
    input  logic             enable,
    input  logic             errcnt_clr,
    input  logic [NBITS-1:0] din,
    output logic [NBITS-1:0] dout,
    output logic             valid,
    output logic             biterr,
    output logic [ERRW-1:0]  errcnt
);

    localparam logic [ERRW-1:0] ERR_SAT = ERRW'(err_sat(ERRW));

    logic             armed;
    logic             load;
    logic [ENDLY-1:0] en_dly;
    logic             quiet;
    logic [NBITS-1:0] hist [NPHASE];
    logic             mismatch;

    // A request arriving on the boundary itself loads directly; the latch
    // only carries requests that arrive earlier in the period.
    assign load = boundary & (armed | capture | enable);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed <= 1'b0;
        end else if (load) begin
            armed <= 1'b0;
        end else if (capture) begin
            armed <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout  <= '0;
            valid <= 1'b0;
        end else begin
            valid <= load;
            if (load) begin
                dout <= din;
            end
        end
    end

    generate
        if (ENDLY == 1) begin : g_dly_one
            always_ff @(posedge clk or posedge rst) begin
                if (rst) en_dly <= '0;
                else     en_dly <= enable;
            end
        end else begin : g_dly_shift
            always_ff @(posedge clk or posedge rst) begin
                if (rst) en_dly <= '0;
                else     en_dly <= {en_dly[ENDLY-2:0], enable};
            end
        end
    endgenerate

    // The stream needs ENDLY cycles after enable falls before the
    // repeat pattern is trustworthy again.
    assign quiet = ~enable & ~(|en_dly);

    // History advances only while streaming is off, so the comparison is
    // always against the word NPHASE idle cycles back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NPHASE; i++) hist[i] <= '0;
        end else if (!enable) begin
            hist[0] <= din;
            for (int i = 1; i < NPHASE; i++) hist[i] <= hist[i-1];
        end
    end

    assign mismatch = (din != hist[NPHASE-1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            biterr <= 1'b0;
        end else if (quiet) begin
            biterr <= mismatch;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            errcnt <= '0;
        end else if (errcnt_clr) begin
            errcnt <= '0;
        end else if (quiet && mismatch && (errcnt != ERR_SAT)) begin
            errcnt <= errcnt + 1'b1;
        end
    end

endmodule

// File: rtl/surf_multi_byte_capture.sv
// -----------------------------------------------------------------------------
// surf_multi_byte_capture
// Multi-channel byte capture for the SURF DOUT path. Owns the byte-period
// phase counter (realigned by sync_i) and replicates one capture channel
// per byte lane.
// Ports:
//   sysclk_i, rst_i : system clock, async active-high reset
//   sync_i          : forces the phase counter to 0
//   dout_sync_o     : high while phase == NPHASE-1 (OSERDES alignment)
//   capture_i       : per-channel one-shot capture request
//   enable_i        : per-channel continuous streaming enable
//   errcnt_clr_i    : clears all error counters
//   dout_i / dout_o : packed words, channel k at [k*NBITS +: NBITS]
//   dout_valid_o    : per-channel store-update pulse
//   dout_biterr_o   : per-channel repeat-pattern mismatch flag
//   errcnt_o        : packed counters, channel k at [k*ERRW +: ERRW]
// -----------------------------------------------------------------------------
module surf_multi_byte_capture
    import surf_capture_pkg::*;
#(
    parameter int NCHAN  = 2,
    parameter int NBITS  = 8,
    parameter int NPHASE = 2,
    parameter int ENDLY  = 16,
    parameter int ERRW   = 16
) (
    input  logic                   sysclk_i,
    input  logic                   rst_i,
    input  logic                   sync_i,
    output logic                   dout_sync_o,
    input  logic [NCHAN-1:0]       capture_i,
    input  logic [NCHAN-1:0]       enable_i,
    input  logic                   errcnt_clr_i,
    input  logic [NCHAN*NBITS-1:0] dout_i,
    output logic [NCHAN*NBITS-1:0] dout_o,
    output logic [NCHAN-1:0]       dout_valid_o,
    output logic [NCHAN-1:0]       dout_biterr_o,
    output logic [NCHAN*ERRW-1:0]  errcnt_o
);

    localparam int            PW   = phase_w(NPHASE);
    localparam logic [PW-1:0] LAST = PW'(NPHASE - 1);

    generate
        if (!nphase_legal(NPHASE) || !endly_legal(ENDLY) || !errw_legal(ERRW)) begin : g_bad_param
            $error("surf_multi_byte_capture: NPHASE, ENDLY or ERRW out of range");
        end
    endgenerate

    logic [PW-1:0] phase;
    logic [PW-1:0] phase_nxt;
    logic          boundary;

    assign boundary = (phase == LAST);

    always_comb begin
        phase_nxt = phase + 1'b1;
        if (sync_i || boundary) begin
            phase_nxt = '0;
        end
    end

    // dout_sync_o decodes the next phase so it lines up with phase itself.
    always_ff @(posedge sysclk_i or posedge rst_i) begin
        if (rst_i) begin
            phase       <= '0;
            dout_sync_o <= 1'b0;
        end else begin
            phase       <= phase_nxt;
            dout_sync_o <= (phase_nxt == LAST);
        end
    end

    for (genvar k = 0; k < NCHAN; k++) begin : g_chan
        surf_byte_capture_chan #(
            .NBITS  (NBITS),
            .NPHASE (NPHASE),
            .ENDLY  (ENDLY),
            .ERRW   (ERRW)
        ) u_chan (
            .clk        (sysclk_i),
            .rst        (rst_i),
            .boundary   (boundary),
            .capture    (capture_i[k]),
            .enable     (enable_i[k]),
            .errcnt_clr (errcnt_clr_i),
            .din        (dout_i[k*NBITS +: NBITS]),
            .dout       (dout_o[k*NBITS +: NBITS]),
            .valid      (dout_valid_o[k]),
            .biterr     (dout_biterr_o[k]),
            .errcnt     (errcnt_o[k*ERRW +: ERRW])
        );
    end

endmodule

// File: tb/tb_surf_multi_byte_capture.sv
// Directed bench: instance "a" uses the default parameters (NPHASE=2,
// ENDLY=16, ERRW=16); instance "b" uses NPHASE=4, ENDLY=4, ERRW=4 for the
// resync and saturation scenarios. Both share the same inputs.
module tb_surf_multi_byte_capture;

    logic        sysclk;
    logic        rst;
    logic        sync;
    logic        clr;
    logic [1:0]  capture;
    logic [1:0]  enable;
    logic [15:0] din;

    logic [15:0] dout_a,   dout_b;
    logic [1:0]  valid_a,  valid_b;
    logic [1:0]  biterr_a, biterr_b;
    logic [31:0] errcnt_a;
    logic [7:0]  errcnt_b;
    logic        dsync_a,  dsync_b;

    int n_cmp;
    int n_bad;

    surf_multi_byte_capture #(
        .NCHAN(2), .NBITS(8), .NPHASE(2), .ENDLY(16), .ERRW(16)
    ) dut_a (
        .sysclk_i      (sysclk),
        .rst_i         (rst),
        .sync_i        (sync),
        .dout_sync_o   (dsync_a),
        .capture_i     (capture),
        .enable_i      (enable),
        .errcnt_clr_i  (clr),
        .dout_i        (din),
        .dout_o        (dout_a),
        .dout_valid_o  (valid_a),
        .dout_biterr_o (biterr_a),
        .errcnt_o      (errcnt_a)
    );

    surf_multi_byte_capture #(
        .NCHAN(2), .NBITS(8), .NPHASE(4), .ENDLY(4), .ERRW(4)
    ) dut_b (
        .sysclk_i      (sysclk),
        .rst_i         (rst),
        .sync_i        (sync),
        .dout_sync_o   (dsync_b),
        .capture_i     (capture),
        .enable_i      (enable),
        .errcnt_clr_i  (clr),
        .dout_i        (din),
        .dout_o        (dout_b),
        .dout_valid_o  (valid_b),
        .dout_biterr_o (biterr_b),
        .errcnt_o      (errcnt_b)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    task automatic step();
        @(posedge sysclk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        n_cmp++;
        if ({dout_a, valid_a, biterr_a, errcnt_a, dsync_a} !== 53'd0) begin
            n_bad++;
            $display("FAIL reset_a: got %h/%b/%b/%h/%b want all zero", dout_a, valid_a, biterr_a, errcnt_a, dsync_a);
        end
        n_cmp++;
        if ({dout_b, valid_b, biterr_b, errcnt_b, dsync_b} !== 29'd0) begin
            n_bad++;
            $display("FAIL reset_b: got %h/%b/%b/%h/%b want all zero", dout_b, valid_b, biterr_b, errcnt_b, dsync_b);
        end
        #1 rst = 1'b0;
    endtask

    task automatic test_streaming();
        logic [7:0] exp_d;
        sync = 1'b1;
        enable = 2'b00;
        step();
        sync = 1'b0;
        enable = 2'b01;
        for (int j = 0; j < 8; j++) begin
            din = {8'h77, 8'(8'h10 + j)};
            step();
            // phase 0 on even j (no load), boundary on odd j (load)
            n_cmp++;
            if (valid_a[0] !== (j % 2 == 1)) begin
                n_bad++;
                $display("FAIL stream_valid0 j=%0d: got %b want %b", j, valid_a[0], (j % 2 == 1));
            end
            n_cmp++;
            if (dsync_a !== (j % 2 == 0)) begin
                n_bad++;
                $display("FAIL stream_dsync j=%0d: got %b want %b", j, dsync_a, (j % 2 == 0));
            end
            n_cmp++;
            if (valid_a[1] !== 1'b0 || dout_a[15:8] !== 8'h00) begin
                n_bad++;
                $display("FAIL stream_ch1 j=%0d: got valid=%b dout=%h want 0/00", j, valid_a[1], dout_a[15:8]);
            end
            if (j > 0) begin
                exp_d = (j % 2 == 1) ? 8'(8'h10 + j) : 8'(8'h10 + j - 1);
                n_cmp++;
                if (dout_a[7:0] !== exp_d) begin
                    n_bad++;
                    $display("FAIL stream_dout0 j=%0d: got %h want %h", j, dout_a[7:0], exp_d);
                end
            end
        end
        enable = 2'b00;
    endtask

    task automatic test_oneshot_phase0();
        logic exp_v;
        sync = 1'b1;
        step();
        sync = 1'b0;
        capture = 2'b10;
        din = 16'hA5_00;
        step();
        capture = 2'b00;
        for (int j = 0; j < 6; j++) begin
            if (j > 0) step();
            exp_v = (j == 1);
            n_cmp++;
            if (valid_a[1] !== exp_v) begin
                n_bad++;
                $display("FAIL oneshot_valid1 j=%0d: got %b want %b", j, valid_a[1], exp_v);
            end
        end
        n_cmp++;
        if (dout_a[15:8] !== 8'hA5) begin
            n_bad++;
            $display("FAIL oneshot_dout1: got %h want a5", dout_a[15:8]);
        end
    endtask

    task automatic test_coincident();
        sync = 1'b1;
        step();
        sync = 1'b0;
        step();
        capture = 2'b10;
        din = 16'h3C_00;
        step();
        capture = 2'b00;
        n_cmp++;
        if (valid_a[1] !== 1'b1 || dout_a[15:8] !== 8'h3C) begin
            n_bad++;
            $display("FAIL coinc_load: got valid=%b dout=%h want 1/3c", valid_a[1], dout_a[15:8]);
        end
        din = 16'hC3_00;
        for (int j = 0; j < 2; j++) begin
            step();
            n_cmp++;
            if (valid_a[1] !== 1'b0 || dout_a[15:8] !== 8'h3C) begin
                n_bad++;
                $display("FAIL coinc_noreload j=%0d: got valid=%b dout=%h want 0/3c", j, valid_a[1], dout_a[15:8]);
            end
        end
    endtask

    task automatic test_resync();
        logic [4:0] exp_seq;
        sync = 1'b1;
        step();
        sync = 1'b0;
        step();
        step();
        n_cmp++;
        if (dsync_b !== 1'b0) begin
            n_bad++;
            $display("FAIL resync_pre: got %b want 0", dsync_b);
        end
        sync = 1'b1;
        step();
        sync = 1'b0;
        n_cmp++;
        if (dsync_b !== 1'b0) begin
            n_bad++;
            $display("FAIL resync_at0: got %b want 0", dsync_b);
        end
        exp_seq = 5'b00100;
        for (int j = 0; j < 5; j++) begin
            step();
            n_cmp++;
            if (dsync_b !== exp_seq[j]) begin
                n_bad++;
                $display("FAIL resync_seq j=%0d: got %b want %b", j, dsync_b, exp_seq[j]);
            end
        end
    endtask

    task automatic test_error_count();
        int t;
        logic [7:0] w0;
        logic [7:0] w1;
        logic [15:0] exp_c;
        logic exp_e;
        enable = 2'b00;
        t = 0;
        for (int j = 0; j < 30; j++) begin
            w0 = (t % 2 == 1) ? 8'h55 : 8'hAA;
            w1 = (t % 2 == 1) ? 8'h0F : 8'hF0;
            if (j == 22) w0 = w0 ^ 8'h01;
            din = {w1, w0};
            clr = (j == 20);
            step();
            t++;
            // corrupted word mismatches once entering and once as history
            exp_c = (j >= 24) ? 16'd2 : ((j >= 22) ? 16'd1 : 16'd0);
            exp_e = (j == 22) || (j == 24);
            if (j >= 20) begin
                n_cmp++;
                if (errcnt_a[15:0] !== exp_c) begin
                    n_bad++;
                    $display("FAIL err_cnt0 j=%0d: got %0d want %0d", j, errcnt_a[15:0], exp_c);
                end
            end
            if (j >= 21) begin
                n_cmp++;
                if (biterr_a[0] !== exp_e) begin
                    n_bad++;
                    $display("FAIL err_biterr0 j=%0d: got %b want %b", j, biterr_a[0], exp_e);
                end
            end
        end
        clr = 1'b0;
        enable = 2'b01;
        for (int j = 0; j < 4; j++) begin
            din = {((t % 2 == 1) ? 8'h0F : 8'hF0), 8'h99};
            step();
            t++;
        end
        enable = 2'b00;
        for (int n = 1; n <= 17; n++) begin
            din = {((t % 2 == 1) ? 8'h0F : 8'hF0), 8'(n)};
            step();
            t++;
            exp_c = (n == 17) ? 16'd3 : 16'd2;
            n_cmp++;
            if (errcnt_a[15:0] !== exp_c || biterr_a[0] !== (n == 17)) begin
                n_bad++;
                $display("FAIL err_suppress n=%0d: got cnt=%0d biterr=%b want %0d/%b", n, errcnt_a[15:0], biterr_a[0], exp_c, (n == 17));
            end
        end
        n_cmp++;
        if (errcnt_a[31:16] !== 16'd0 || biterr_a[1] !== 1'b0) begin
            n_bad++;
            $display("FAIL err_ch1: got cnt=%0d biterr=%b want 0/0", errcnt_a[31:16], biterr_a[1]);
        end
    endtask

    task automatic test_saturation();
        logic [3:0] exp_c;
        logic chk;
        enable = 2'b00;
        for (int j = 0; j <= 35; j++) begin
            din = {8'h00, 8'(j)};
            clr = (j == 8) || (j == 31) || (j == 34);
            step();
            chk = 1'b1;
            case (j)
                8:       exp_c = 4'd0;
                9:       exp_c = 4'd1;
                22:      exp_c = 4'd14;
                23:      exp_c = 4'd15;
                30:      exp_c = 4'd15;
                31:      exp_c = 4'd0;
                32:      exp_c = 4'd1;
                33:      exp_c = 4'd2;
                34:      exp_c = 4'd0;
                35:      exp_c = 4'd1;
                default: begin exp_c = 4'd0; chk = 1'b0; end
            endcase
            if (chk) begin
                n_cmp++;
                if (errcnt_b[3:0] !== exp_c) begin
                    n_bad++;
                    $display("FAIL sat_cnt0 j=%0d: got %0d want %0d", j, errcnt_b[3:0], exp_c);
                end
            end
        end
        clr = 1'b0;
    endtask

    task automatic test_reset_mid_arm();
        enable = 2'b00;
        sync = 1'b1;
        step();
        sync = 1'b0;
        capture = 2'b11;
        din = 16'hBEEF;
        step();
        capture = 2'b00;
        rst = 1'b1;
        #2;
        n_cmp++;
        if ({dout_a, valid_a, biterr_a, errcnt_a, dsync_a} !== 53'd0) begin
            n_bad++;
            $display("FAIL rst_mid_a: got %h/%b/%b/%h/%b want all zero", dout_a, valid_a, biterr_a, errcnt_a, dsync_a);
        end
        n_cmp++;
        if ({dout_b, valid_b, biterr_b, errcnt_b, dsync_b} !== 29'd0) begin
            n_bad++;
            $display("FAIL rst_mid_b: got %h/%b/%b/%h/%b want all zero", dout_b, valid_b, biterr_b, errcnt_b, dsync_b);
        end
        #2;
        rst = 1'b0;
        for (int j = 0; j < 4; j++) begin
            step();
            n_cmp++;
            if (valid_a !== 2'b00 || dout_a !== 16'h0000 || valid_b !== 2'b00) begin
                n_bad++;
                $display("FAIL rst_mid_novalid j=%0d: got va=%b da=%h vb=%b want 00/0000/00", j, valid_a, dout_a, valid_b);
            end
        end
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        rst     = 1'b1;
        sync    = 1'b0;
        clr     = 1'b0;
        capture = 2'b00;
        enable  = 2'b00;
        din     = 16'h0000;
        test_reset();
        test_streaming();
        test_oneshot_phase0();
        test_coincident();
        test_resync();
        test_error_count();
        test_saturation();
        test_reset_mid_arm();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
